pic_core_n: RTL and testbench
=============================

# pic_core_n

Parametrised, fully synchronous successor to the 8259-style control logic. It handles NUM_IRQ request lines and runs the ICW1/ICW2/ICW4 initialisation sequence. It also provides the interrupt mask, the in-service (ISR) and request (IRR) registers, rotating priority, specific and non-specific EOI, auto-EOI, and the two-strobe acknowledge that returns a vector. It sits between the CPU-side data bus buffer and the external IR pins. This is single-controller mode only; there is no cascade and no ICW3.

## Interface
- NUM_IRQ, 8, number of request lines, 2..BUS_W
- BUS_W, 8, data bus width, ≥ 8
- IDX_W, $clog2(NUM_IRQ), request index width (derived, not overridable)

Ports:
- clk  in  1  single clock; everything samples on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  one-cycle write strobe
- rd_en  in  1  one-cycle read strobe
- a0  in  1  register select
- wr_data  in  BUS_W  write data
- rd_data  out  BUS_W  read data, registered
- irq_in  in  NUM_IRQ  request lines, already synchronous to clk
- inta  in  1  acknowledge strobe, one cycle per acknowledge pulse
- int_out  out  1  interrupt request to the CPU, registered
- vec_out  out  BUS_W  vector
- vec_valid  out  1  one-cycle qualifier for vec_out

## Operation
- **Reset values:**
  - Init FSM = S_ICW1.
  - IMR, ISR, IRR, irq_q = 0.
  - ltim = 0, ic4 = 0, aeoi = 0, rot_aeoi = 0, read_sel = IRR, lowest-priority index lp = NUM_IRQ-1.
  - rd_data, vec_out, vec_valid, int_out = 0.
- **Init FSM:** states S_ICW1, S_ICW2, S_ICW4, S_READY.
  - ICW1 = wr_en & !a0 & wr_data[4], accepted in any state. It captures ic4 = bit0 and ltim = bit3.
  - ICW1 clears IMR, ISR, IRR, rot_aeoi and aeoi, sets lp = NUM_IRQ-1 and read_sel = IRR, aborts any acknowledge in progress, and moves to S_ICW2.
  - S_ICW2: a write with a0 = 1 sets vec_base = wr_data[BUS_W-1:IDX_W]. Next state is S_ICW4 if ic4 is set, else S_READY.
  - S_ICW4: a write with a0 = 1 sets aeoi = bit1, then S_READY.
  - In any state other than S_READY, writes that are not ICW1 and do not match the expected ICW are ignored. int_out stays 0.
- **S_READY writes:**
  - a0 = 1 → IMR = wr_data[NUM_IRQ-1:0].
  - a0 = 0, bit4 = 0, bit3 = 0 → OCW2.
  - a0 = 0, bit4 = 0, bit3 = 1 → OCW3.
- **OCW2 commands, by bits[7:5]** (H = highest-priority set ISR bit, L = wr_data[IDX_W-1:0]):
  - 001: clear ISR[H].
  - 011: clear ISR[L].
  - 101: clear ISR[H], then lp = H.
  - 111: clear ISR[L], then lp = L.
  - 100: rot_aeoi = 1.
  - 000: rot_aeoi = 0.
  - 110: lp = L.
  - 010: no-op.
  - L ≥ NUM_IRQ: command ignored.
  - Non-specific EOI with ISR = 0: no-op.
- **OCW3:** when bit1 = 1, read_sel = bit0 (0 = IRR, 1 = ISR).
- **Reads:**
  - rd_en & !a0 → rd_data = IRR or ISR per read_sel, zero-extended.
  - rd_en & a0 → rd_data = IMR.
- **IRR:**
  - Edge mode (ltim = 0): irq_q <= irq_in every cycle. IRR[i] is set when irq_in[i] & !irq_q[i], and cleared when ISR[i] is set or irq_in[i] = 0.
  - Level mode: IRR <= irq_in.
- **Priority:** rotating. Order runs lp+1 (highest), lp+2, …, lp (lowest), modulo NUM_IRQ.
- **int_out:** pend = IRR & ~IMR. int_out = 1 in S_READY when pend has a bit of strictly higher priority than every ISR bit (fully nested).
- **Acknowledge FSM:** states A_IDLE, A_ACK1, A_ACK2.
  - First inta: winner W = highest pending. Set ISR[W], clear IRR[W], int_out = 0, go to A_ACK1.
  - If nothing is pending, this is a spurious acknowledge: W = NUM_IRQ-1 and no ISR change.
  - Second inta: vec_out = {vec_base, W}, vec_valid = 1, return to A_IDLE.
  - If aeoi is set, the second inta also clears ISR[W]. If rot_aeoi is also set, lp = W.
  - inta outside S_READY is ignored.
- **Same-cycle precedence:**
  - rst beats everything.
  - ICW1 beats inta.
  - For the same bit, an EOI clear and an ISR set in the same cycle: the set wins.
  - Otherwise the write and the acknowledge both take effect.

## Timing
- irq_in rises in cycle t → IRR set at t+1 → int_out high at t+2.
- A write in cycle t takes effect at t+1.
- rd_data is valid the cycle after rd_en and holds until the next read.
- vec_out/vec_valid appear the cycle after the second inta. vec_valid is high for exactly one cycle; vec_out holds.
- After an EOI, int_out can reassert no earlier than 1 cycle later.

## Structure
- Package pic_pkg holds:
  - the init and acknowledge state enums;
  - the OCW2 command codes;
  - ICW1/OCW decode bit positions.
- Sub-module pic_prio_resolver: combinational rotating priority encoder with inputs (req, lp) and outputs (valid, idx). It is instantiated twice, once on pend and once on ISR.

## Test plan
- **Init and mask:** NUM_IRQ = 8; write ICW1 0x13, ICW2 0x40, ICW4 0x01; IMR = 0x00; pulse irq_in[3] → int_out at +2 cycles. Two inta strobes → vec_out = 0x43, ISR = 0x08, int_out = 0.
- **Nesting and non-specific EOI:** with ISR[3] set, raise irq_in[5] → no int_out. Raise irq_in[1] → int_out. Acknowledge → vector 0x41, ISR = 0x0A. OCW2 0x20 → ISR = 0x08.
- **Auto-EOI rotation:** ICW4 0x03 and OCW2 0x80; requests 2 and 6 raised together → vector for 2, ISR = 0, lp = 2. Next acknowledge → vector for 6.
- **Register readback:** OCW3 0x0B, then rd_en → rd_data = ISR. OCW3 0x0A → IRR. rd_en with a0 = 1 → IMR.
- **Spurious and level mode:** ICW1 0x1B; raise irq_in[4], drop it before the first inta → vector = base|7 and ISR unchanged.
- **Reset and re-init mid-acknowledge:** assert rst, or write ICW1, between the two inta strobes → no vec_valid, all reset values restored. Repeat with NUM_IRQ = 16, BUS_W = 16 and irq_in[12] → vector = base|12.

Source files
------------

// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared types, command codes and decode bit positions for pic_core_n
package pic_pkg;

   typedef enum logic [1:0] {S_ICW1, S_ICW2, S_ICW4, S_READY} init_state_t;
   typedef enum logic [1:0] {A_IDLE, A_ACK1, A_ACK2} ack_state_t;

   localparam logic [2:0] OCW2_CLR_ROT_AEOI = 3'b000;
   localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
   localparam logic [2:0] OCW2_NOP          = 3'b010;
   localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
   localparam logic [2:0] OCW2_SET_ROT_AEOI = 3'b100;
   localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
   localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
   localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

   localparam int ICW1_IC4     = 0;
   localparam int ICW1_LTIM    = 3;
   localparam int ICW1_SEL     = 4;
   localparam int ICW4_AEOI    = 1;
   localparam int OCW_SEL3     = 3;
   localparam int OCW2_CMD_LSB = 5;
   localparam int OCW3_RR      = 1;
   localparam int OCW3_RIS     = 0;

   // 0 = highest priority; the line just after lp is the highest
   function automatic int prio_rank(input int idx, input int low, input int n);
      return (idx + 2 * n - low - 1) % n;
   endfunction

endpackage

// File: rtl/pic_prio_resolver.sv
// rtl/pic_prio_resolver.sv - rotating priority encoder, lp+1 highest down to lp lowest
module pic_prio_resolver #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] lp,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] pos;

   // Walk from lowest to highest priority so the last hit is the winner
   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int k = N; k >= 1; k--) begin
         pos = IW'((int'(lp) + k) % N);
         if (req[pos]) begin
            valid = 1'b1;
            idx   = pos;
         end
      end
   end

endmodule

// File: rtl/pic_core_n.sv
// rtl/pic_core_n.sv - single 8259-style interrupt controller core without cascade
module pic_core_n
   import pic_pkg::*;
#(
   parameter int NUM_IRQ = 8,
   parameter int BUS_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic               a0,
   input  logic [BUS_W-1:0]   wr_data,
   output logic [BUS_W-1:0]   rd_data,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic               inta,
   output logic               int_out,
   output logic [BUS_W-1:0]   vec_out,
   output logic               vec_valid
);

   localparam int IDX_W = $clog2(NUM_IRQ);
   localparam int VB_W  = BUS_W - IDX_W;

   init_state_t        init_q, init_nx;
   ack_state_t         ack_q, ack_nx;
   logic [NUM_IRQ-1:0] imr, imr_nx, isr, isr_nx, irr, irr_nx, irq_q;
   logic               ltim, ltim_nx, ic4, ic4_nx, aeoi, aeoi_nx, rot_aeoi, rot_aeoi_nx;
   logic               read_sel, read_sel_nx, ack_spur, ack_spur_nx;
   logic [IDX_W-1:0]   lp, lp_nx, ack_w, ack_w_nx;
   logic [VB_W-1:0]    vec_base, vec_base_nx;
   logic [BUS_W-1:0]   rd_data_nx, vec_out_nx;
   logic               vec_valid_nx, int_out_nx;

   logic               ready, wr_icw1, wr_ocw2, wr_ocw3, ack_go, l_ok, higher;
   logic [NUM_IRQ-1:0] pend;
   logic               pend_v, isr_v;
   logic [IDX_W-1:0]   pend_idx, isr_idx, l_idx;

   assign ready   = (init_q == S_READY);
   assign wr_icw1 = wr_en && !a0 && wr_data[ICW1_SEL];
   assign wr_ocw2 = ready && wr_en && !a0 && !wr_data[ICW1_SEL] && !wr_data[OCW_SEL3];
   assign wr_ocw3 = ready && wr_en && !a0 && !wr_data[ICW1_SEL] && wr_data[OCW_SEL3];
   assign ack_go  = ready && inta && !wr_icw1;
   assign l_idx   = wr_data[IDX_W-1:0];
   assign l_ok    = int'(l_idx) < NUM_IRQ;
   assign pend    = irr & ~imr;

   pic_prio_resolver #(.N(NUM_IRQ), .IW(IDX_W)) u_pend_prio (
      .req(pend), .lp(lp), .valid(pend_v), .idx(pend_idx));
   pic_prio_resolver #(.N(NUM_IRQ), .IW(IDX_W)) u_isr_prio (
      .req(isr), .lp(lp), .valid(isr_v), .idx(isr_idx));

   // Fully nested: only a request that outranks everything in service interrupts
   assign higher = pend_v && (!isr_v ||
      prio_rank(int'(pend_idx), int'(lp), NUM_IRQ) < prio_rank(int'(isr_idx), int'(lp), NUM_IRQ));

   always_comb begin
      init_nx      = init_q;
      ack_nx       = ack_q;
      imr_nx       = imr;
      isr_nx       = isr;
      ltim_nx      = ltim;
      ic4_nx       = ic4;
      aeoi_nx      = aeoi;
      rot_aeoi_nx  = rot_aeoi;
      read_sel_nx  = read_sel;
      ack_spur_nx  = ack_spur;
      lp_nx        = lp;
      ack_w_nx     = ack_w;
      vec_base_nx  = vec_base;
      rd_data_nx   = rd_data;
      vec_out_nx   = vec_out;
      vec_valid_nx = 1'b0;
      int_out_nx   = ready && higher && (ack_q != A_ACK1) && !ack_go;
      irr_nx       = ltim ? irq_in : ((irr & irq_in & ~isr) | (irq_in & ~irq_q));

      case (init_q)
         S_ICW2: if (wr_en && a0) begin
            vec_base_nx = wr_data[BUS_W-1:IDX_W];
            init_nx     = ic4 ? S_ICW4 : S_READY;
         end
         S_ICW4: if (wr_en && a0) begin
            aeoi_nx = wr_data[ICW4_AEOI];
            init_nx = S_READY;
         end
         default: ;
      endcase

      if (ready && wr_en && a0) imr_nx = wr_data[NUM_IRQ-1:0];
      if (wr_ocw3 && wr_data[OCW3_RR]) read_sel_nx = wr_data[OCW3_RIS];
      if (wr_ocw2) begin
         case (wr_data[OCW2_CMD_LSB +: 3])
            OCW2_NS_EOI:       if (isr_v) isr_nx[isr_idx] = 1'b0;
            OCW2_SP_EOI:       if (l_ok) isr_nx[l_idx] = 1'b0;
            OCW2_ROT_NS_EOI:   if (isr_v) begin isr_nx[isr_idx] = 1'b0; lp_nx = isr_idx; end
            OCW2_ROT_SP_EOI:   if (l_ok) begin isr_nx[l_idx] = 1'b0; lp_nx = l_idx; end
            OCW2_SET_ROT_AEOI: rot_aeoi_nx = 1'b1;
            OCW2_CLR_ROT_AEOI: rot_aeoi_nx = 1'b0;
            OCW2_SET_PRIO:     if (l_ok) lp_nx = l_idx;
            OCW2_NOP:          ;
         endcase
      end

      // Acknowledge runs after the write so an ISR set beats an EOI clear of the same bit
      if (ack_go) begin
         if (ack_q == A_ACK1) begin
            vec_out_nx   = {vec_base, ack_w};
            vec_valid_nx = 1'b1;
            if (aeoi && !ack_spur) begin
               isr_nx[ack_w] = 1'b0;
               if (rot_aeoi) lp_nx = ack_w;
            end
            ack_nx = A_ACK2;
         end else begin
            ack_spur_nx = !pend_v;
            ack_w_nx    = pend_v ? pend_idx : IDX_W'(NUM_IRQ - 1);
            if (pend_v) begin
               isr_nx[pend_idx] = 1'b1;
               irr_nx[pend_idx] = 1'b0;
            end
            ack_nx = A_ACK1;
         end
      end else if (ack_q == A_ACK2) begin
         ack_nx = A_IDLE;
      end

      if (rd_en) rd_data_nx = a0 ? BUS_W'(imr) : (read_sel ? BUS_W'(isr) : BUS_W'(irr));

      if (wr_icw1) begin
         ic4_nx      = wr_data[ICW1_IC4];
         ltim_nx     = wr_data[ICW1_LTIM];
         imr_nx      = '0;
         isr_nx      = '0;
         irr_nx      = '0;
         rot_aeoi_nx = 1'b0;
         aeoi_nx     = 1'b0;
         lp_nx       = IDX_W'(NUM_IRQ - 1);
         read_sel_nx = 1'b0;
         ack_nx      = A_IDLE;
         ack_spur_nx = 1'b0;
         int_out_nx  = 1'b0;
         init_nx     = S_ICW2;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         init_q    <= S_ICW1;
         ack_q     <= A_IDLE;
         imr       <= '0;
         isr       <= '0;
         irr       <= '0;
         irq_q     <= '0;
         ltim      <= 1'b0;
         ic4       <= 1'b0;
         aeoi      <= 1'b0;
         rot_aeoi  <= 1'b0;
         read_sel  <= 1'b0;
         ack_spur  <= 1'b0;
         lp        <= IDX_W'(NUM_IRQ - 1);
         ack_w     <= '0;
         vec_base  <= '0;
         rd_data   <= '0;
         vec_out   <= '0;
         vec_valid <= 1'b0;
         int_out   <= 1'b0;
      end else begin
         init_q    <= init_nx;
         ack_q     <= ack_nx;
         imr       <= imr_nx;
         isr       <= isr_nx;
         irr       <= irr_nx;
         irq_q     <= irq_in;
         ltim      <= ltim_nx;
         ic4       <= ic4_nx;
         aeoi      <= aeoi_nx;
         rot_aeoi  <= rot_aeoi_nx;
         read_sel  <= read_sel_nx;
         ack_spur  <= ack_spur_nx;
         lp        <= lp_nx;
         ack_w     <= ack_w_nx;
         vec_base  <= vec_base_nx;
         rd_data   <= rd_data_nx;
         vec_out   <= vec_out_nx;
         vec_valid <= vec_valid_nx;
         int_out   <= int_out_nx;
      end
   end

endmodule

// File: tb/tb_pic_core_n.sv
// tb/tb_pic_core_n.sv - directed self-checking bench for pic_core_n (8 and 16 line builds)
module tb_pic_core_n;

   logic        clk = 1'b0, rst = 1'b1;
   logic        wr_en = 1'b0, rd_en = 1'b0, a0 = 1'b0, inta = 1'b0;
   logic [7:0]  wr_data = '0, irq_in = '0;
   logic [7:0]  rd_data, vec_out;
   logic        int_out, vec_valid;

   logic        wr_en2 = 1'b0, rd_en2 = 1'b0, a02 = 1'b0, inta2 = 1'b0;
   logic [15:0] wr_data2 = '0, irq_in2 = '0;
   logic [15:0] rd_data2, vec_out2;
   logic        int_out2, vec_valid2;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   pic_core_n #(.NUM_IRQ(8), .BUS_W(8)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .a0(a0), .wr_data(wr_data),
      .rd_data(rd_data), .irq_in(irq_in), .inta(inta), .int_out(int_out),
      .vec_out(vec_out), .vec_valid(vec_valid));

   pic_core_n #(.NUM_IRQ(16), .BUS_W(16)) dut16 (
      .clk(clk), .rst(rst), .wr_en(wr_en2), .rd_en(rd_en2), .a0(a02), .wr_data(wr_data2),
      .rd_data(rd_data2), .irq_in(irq_in2), .inta(inta2), .int_out(int_out2),
      .vec_out(vec_out2), .vec_valid(vec_valid2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic a, input logic [7:0] d);
      a0 = a; wr_data = d; wr_en = 1'b1;
      tick();
      wr_en = 1'b0; a0 = 1'b0;
   endtask

   task automatic rd(input logic a);
      a0 = a; rd_en = 1'b1;
      tick();
      rd_en = 1'b0; a0 = 1'b0;
   endtask

   task automatic ack();
      inta = 1'b1;
      tick();
      inta = 1'b0;
   endtask

   task automatic wr2(input logic a, input logic [15:0] d);
      a02 = a; wr_data2 = d; wr_en2 = 1'b1;
      tick();
      wr_en2 = 1'b0; a02 = 1'b0;
   endtask

   task automatic rd2(input logic a);
      a02 = a; rd_en2 = 1'b1;
      tick();
      rd_en2 = 1'b0; a02 = 1'b0;
   endtask

   task automatic ack2();
      inta2 = 1'b1;
      tick();
      inta2 = 1'b0;
   endtask

   task automatic test_reset();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL rst_int got=%0h exp=0", int_out); end
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL rst_vv got=%0h exp=0", vec_valid); end
      checks++; if (vec_out !== 8'h00) begin failures++; $display("FAIL rst_vec got=%0h exp=0", vec_out); end
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_rd got=%0h exp=0", rd_data); end
      checks++; if (vec_out2 !== 16'h0) begin failures++; $display("FAIL rst_vec16 got=%0h exp=0", vec_out2); end
      irq_in = 8'h01;
      tick(); tick(); tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL uninit_int got=%0h exp=0", int_out); end
      rd(1'b1);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL rst_imr got=%0h exp=0", rd_data); end
      irq_in = 8'h00;
      tick();
   endtask

   task automatic test_init_mask();
      wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h01); wr(1'b1, 8'h00);
      irq_in = 8'h08;
      tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL int_t1 got=%0h exp=0", int_out); end
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL int_t2 got=%0h exp=1", int_out); end
      ack();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL int_ack1 got=%0h exp=0", int_out); end
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL vv_ack1 got=%0h exp=0", vec_valid); end
      ack();
      checks++; if (vec_valid !== 1'b1) begin failures++; $display("FAIL vv_ack2 got=%0h exp=1", vec_valid); end
      checks++; if (vec_out !== 8'h43) begin failures++; $display("FAIL vec_irq3 got=%0h exp=43", vec_out); end
      tick();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL vv_pulse got=%0h exp=0", vec_valid); end
      checks++; if (vec_out !== 8'h43) begin failures++; $display("FAIL vec_hold got=%0h exp=43", vec_out); end
      wr(1'b0, 8'h0B); rd(1'b0);
      checks++; if (rd_data !== 8'h08) begin failures++; $display("FAIL isr_irq3 got=%0h exp=08", rd_data); end
   endtask

   task automatic test_nesting();
      irq_in = 8'h28;
      tick(); tick(); tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL nest_low got=%0h exp=0", int_out); end
      irq_in = 8'h2A;
      tick(); tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL nest_high got=%0h exp=1", int_out); end
      ack(); ack();
      checks++; if (vec_out !== 8'h41) begin failures++; $display("FAIL vec_irq1 got=%0h exp=41", vec_out); end
      rd(1'b0);
      checks++; if (rd_data !== 8'h0A) begin failures++; $display("FAIL isr_nest got=%0h exp=0a", rd_data); end
      wr(1'b0, 8'h20); rd(1'b0);
      checks++; if (rd_data !== 8'h08) begin failures++; $display("FAIL isr_eoi got=%0h exp=08", rd_data); end
      wr(1'b0, 8'h20);
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL eoi_same got=%0h exp=0", int_out); end
      tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL eoi_next got=%0h exp=1", int_out); end
      ack(); ack();
      checks++; if (vec_out !== 8'h45) begin failures++; $display("FAIL vec_irq5 got=%0h exp=45", vec_out); end
      wr(1'b0, 8'h20);
      irq_in = 8'h00;
      tick();
   endtask

   task automatic test_aeoi_rotation();
      wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h03); wr(1'b0, 8'h80);
      irq_in = 8'h44;
      tick(); tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL aeoi_int got=%0h exp=1", int_out); end
      ack(); ack();
      checks++; if (vec_out !== 8'h42) begin failures++; $display("FAIL vec_irq2 got=%0h exp=42", vec_out); end
      wr(1'b0, 8'h0B); rd(1'b0);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL isr_aeoi got=%0h exp=00", rd_data); end
      irq_in = 8'h46;
      tick(); tick();
      ack(); ack();
      checks++; if (vec_out !== 8'h46) begin failures++; $display("FAIL vec_rot6 got=%0h exp=46", vec_out); end
      ack(); ack();
      checks++; if (vec_out !== 8'h41) begin failures++; $display("FAIL vec_rot1 got=%0h exp=41", vec_out); end
   endtask

   task automatic test_readback();
      wr(1'b1, 8'hA5); rd(1'b1);
      checks++; if (rd_data !== 8'hA5) begin failures++; $display("FAIL rd_imr got=%0h exp=a5", rd_data); end
      wr(1'b0, 8'h0A);
      irq_in = 8'h47;
      tick();
      rd(1'b0);
      checks++; if (rd_data !== 8'h01) begin failures++; $display("FAIL rd_irr got=%0h exp=01", rd_data); end
      tick();
      checks++; if (rd_data !== 8'h01) begin failures++; $display("FAIL rd_hold got=%0h exp=01", rd_data); end
      irq_in = 8'h00;
      tick();
   endtask

   task automatic test_spurious_level();
      wr(1'b0, 8'h1B); wr(1'b1, 8'h40); wr(1'b1, 8'h01);
      irq_in = 8'h10;
      tick(); tick();
      checks++; if (int_out !== 1'b1) begin failures++; $display("FAIL lvl_int got=%0h exp=1", int_out); end
      irq_in = 8'h00;
      tick(); tick();
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL lvl_drop got=%0h exp=0", int_out); end
      ack(); ack();
      checks++; if (vec_out !== 8'h47) begin failures++; $display("FAIL vec_spur got=%0h exp=47", vec_out); end
      checks++; if (vec_valid !== 1'b1) begin failures++; $display("FAIL vv_spur got=%0h exp=1", vec_valid); end
      wr(1'b0, 8'h0B); rd(1'b0);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL isr_spur got=%0h exp=00", rd_data); end
   endtask

   task automatic test_reset_mid_ack();
      irq_in = 8'h04;
      tick(); tick();
      ack();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (vec_out !== 8'h00) begin failures++; $display("FAIL mid_rst_vec got=%0h exp=0", vec_out); end
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mid_rst_rd got=%0h exp=0", rd_data); end
      ack();
      checks++; if (vec_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_vv got=%0h exp=0", vec_valid); end
      checks++; if (int_out !== 1'b0) begin failures++; $display("FAIL mid_rst_int got=%0h exp=0", int_out); end
      wr(1'b0, 8'h13); wr(1'b1, 8'h40); wr(1'b1, 8'h01);
      rd(1'b1);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mid_rst_imr got=%0h exp=0", rd_data); end
      rd(1'b0);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mid_rst_irr got=%0h exp=0", rd_data); end
      wr(1'b0, 8'h0B); rd(1'b0);
      checks++; if (rd_data !== 8'h00) begin failures++; $display("FAIL mid_rst_isr got=%0h exp=0", rd_data); end
      irq_in = 8'h00;
      tick();
   endtask

   task automatic test_wide_icw1_mid_ack();
      wr2(1'b0, 16'h0013); wr2(1'b1, 16'h0120); wr2(1'b1, 16'h0001);
      irq_in2 = 16'h1000;
      tick(); tick();
      checks++; if (int_out2 !== 1'b1) begin failures++; $display("FAIL w_int got=%0h exp=1", int_out2); end
      ack2();
      wr2(1'b0, 16'h0013);
      ack2();
      checks++; if (vec_valid2 !== 1'b0) begin failures++; $display("FAIL w_abort_vv got=%0h exp=0", vec_valid2); end
      checks++; if (int_out2 !== 1'b0) begin failures++; $display("FAIL w_abort_int got=%0h exp=0", int_out2); end
      wr2(1'b1, 16'h0120); wr2(1'b1, 16'h0001);
      irq_in2 = 16'h0000;
      tick();
      irq_in2 = 16'h1000;
      tick(); tick();
      checks++; if (int_out2 !== 1'b1) begin failures++; $display("FAIL w_int2 got=%0h exp=1", int_out2); end
      ack2(); ack2();
      checks++; if (vec_out2 !== 16'h012C) begin failures++; $display("FAIL w_vec got=%0h exp=12c", vec_out2); end
      checks++; if (vec_valid2 !== 1'b1) begin failures++; $display("FAIL w_vv got=%0h exp=1", vec_valid2); end
      wr2(1'b0, 16'h000B); rd2(1'b0);
      checks++; if (rd_data2 !== 16'h1000) begin failures++; $display("FAIL w_isr got=%0h exp=1000", rd_data2); end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      test_reset();
      test_init_mask();
      test_nesting();
      test_aeoi_rotation();
      test_readback();
      test_spurious_level();
      test_reset_mid_ack();
      test_wide_icw1_mid_ack();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
